// File: rtl/half_adder.sv
// Half adder with a combinational sum/carry path and a registered path that
// also counts carry events in a saturating counter.
module half_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             in_valid,
    output logic             S,
    output logic             Cout,
    output logic             S_r,
    output logic             Cout_r,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             carry_sat
);

    logic             s_q, s_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_full;

    assign S    = A ^ B;
    assign Cout = A & B;

    assign cnt_full = &cnt_q;

    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid) begin
            s_d     = A ^ B;
            cout_d  = A & B;
            valid_d = 1'b1;
            // Saturate rather than wrap once every bit is set.
            if ((A & B) && !cnt_full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S_r       = s_q;
    assign Cout_r    = cout_q;
    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;
    assign carry_sat = cnt_full;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: vector table, directed registered-path sequences and
// random traffic against an arithmetic reference, on CNT_W=8 and CNT_W=2 builds.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst, A, B, in_valid;

    logic       s8, c8, sr8, cr8, ov8, sat8;
    logic [7:0] cnt8;
    logic       s2, c2, sr2, cr2, ov2, sat2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    // Reference state: what the registered outputs should hold.
    int m_sr, m_cr, m_ov, m_cnt8, m_cnt2;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    always #5 clk = ~clk;

    half_adder #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .S(s8), .Cout(c8), .S_r(sr8), .Cout_r(cr8), .out_valid(ov8),
        .carry_cnt(cnt8), .carry_sat(sat8)
    );

    half_adder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
        .S(s2), .Cout(c2), .S_r(sr2), .Cout_r(cr2), .out_valid(ov2),
        .carry_cnt(cnt2), .carry_sat(sat2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, computed from the current inputs.
    task automatic model_edge();
        int sum;
        sum = int'(A) + int'(B);
        if (rst) begin
            m_sr = 0; m_cr = 0; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (in_valid) begin
            m_sr = sum % 2;
            m_cr = sum / 2;
            m_ov = 1;
            if (sum == 2) begin
                if (m_cnt8 < 255) m_cnt8 = m_cnt8 + 1;
                if (m_cnt2 < 3)   m_cnt2 = m_cnt2 + 1;
            end
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic check_all();
        int sum;
        sum = int'(A) + int'(B);
        check("S8",       32'(s8),   32'(sum % 2));
        check("Cout8",    32'(c8),   32'(sum / 2));
        check("S2",       32'(s2),   32'(sum % 2));
        check("S_r8",     32'(sr8),  32'(m_sr));
        check("Cout_r8",  32'(cr8),  32'(m_cr));
        check("ovalid8",  32'(ov8),  32'(m_ov));
        check("cnt8",     32'(cnt8), 32'(m_cnt8));
        check("sat8",     32'(sat8), 32'(m_cnt8 == 255));
        check("S_r2",     32'(sr2),  32'(m_sr));
        check("ovalid2",  32'(ov2),  32'(m_ov));
        check("cnt2",     32'(cnt2), 32'(m_cnt2));
        check("sat2",     32'(sat2), 32'(m_cnt2 == 3));
    endtask

    task automatic step(input logic r, input logic v, input logic a, input logic b);
        rst = r; in_valid = v; A = a; B = b;
        #1;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        vec_t vecs[4];
        int   seq_exp[5];
        int   e0;

        vecs[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        vecs[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        vecs[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        vecs[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};
        seq_exp = '{1, 2, 3, 3, 3};

        rst = 1'b1; in_valid = 1'b0; A = 1'b0; B = 1'b0;
        m_sr = 0; m_cr = 0; m_ov = 0; m_cnt8 = 0; m_cnt2 = 0;

        // Combinational table, applied while reset is held.
        for (int i = 0; i < 4; i++) begin
            A = vecs[i].a; B = vecs[i].b;
            #10;
            e0 = errors;
            check("vec_S",    32'(s8), 32'(vecs[i].s));
            check("vec_Cout", 32'(c8), 32'(vecs[i].c));
            if (errors == e0) $display("vector %0d%0d pass", vecs[i].a, vecs[i].b);
        end

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_cnt8", 32'(cnt8), 32'd0);
        check("rst_ov",   32'(ov8),  32'd0);

        // Single valid carry pair.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("reg_S_r",  32'(sr8),  32'd0);
        check("reg_Cr",   32'(cr8),  32'd1);
        check("reg_ov",   32'(ov8),  32'd1);
        check("reg_cnt",  32'(cnt8), 32'd1);

        // Hold for three idle edges.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("hold_S_r", 32'(sr8),  32'd0);
            check("hold_Cr",  32'(cr8),  32'd1);
            check("hold_ov",  32'(ov8),  32'd0);
            check("hold_cnt", 32'(cnt8), 32'd1);
        end

        // Non-carry pairs leave the counter alone.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("nc01_S_r", 32'(sr8),  32'd1);
        check("nc01_Cr",  32'(cr8),  32'd0);
        check("nc01_cnt", 32'(cnt8), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("nc10_S_r", 32'(sr8),  32'd1);
        check("nc10_cnt", 32'(cnt8), 32'd1);

        // Saturation on the 2-bit counter.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            check("sat_cnt2", 32'(cnt2), 32'(seq_exp[i]));
            check("sat_flag", 32'(sat2), 32'(i >= 2));
        end

        // Reset wins over a simultaneous valid carry pair.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("prio_S_r", 32'(sr8),  32'd0);
        check("prio_Cr",  32'(cr8),  32'd0);
        check("prio_ov",  32'(ov8),  32'd0);
        check("prio_cnt", 32'(cnt8), 32'd0);
        check("prio_c2",  32'(cnt2), 32'd0);
        check("prio_Cout_during_rst", 32'(c8), 32'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter; legal range 1..32.
REQ-002 clk  input  1  single clock; all sequential logic samples on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; takes effect on the rising edge of clk while high.
REQ-004 A  input  1  addend bit A.
REQ-005 B  input  1  addend bit B.
REQ-006 in_valid  input  1  qualifies A/B for the registered path and the counter.
REQ-007 S  output  1  combinational sum bit, A XOR B.
REQ-008 Cout  output  1  combinational carry bit, A AND B.
REQ-009 S_r  output  1  registered sum of the last valid input pair.
REQ-010 Cout_r  output  1  registered carry of the last valid input pair.
REQ-011 out_valid  output  1  high for one cycle when S_r/Cout_r were updated by the previous edge.
REQ-012 carry_cnt  output  CNT_W  count of accepted input pairs with A=1 and B=1.
REQ-013 carry_sat  output  1  high while carry_cnt equals all-ones.

Function
REQ-014 S and Cout SHALL be purely combinational, independent of clk, rst and in_valid, settling within the same delta/timestep as A/B change.
REQ-015 Truth table SHALL be: 00->S=0,Cout=0; 01->S=1,Cout=0; 10->S=1,Cout=0; 11->S=0,Cout=1.
REQ-016 Arithmetic identity SHALL hold at all times: {Cout,S} == A + B (2-bit unsigned).
REQ-017 On a rising edge with rst=0 and in_valid=1, S_r<=A^B, Cout_r<=A&B, out_valid<=1 (latency one cycle).
REQ-018 On a rising edge with rst=0 and in_valid=0, S_r/Cout_r SHALL hold, out_valid<=0.
REQ-019 On a rising edge with rst=0, in_valid=1, A=1, B=1 and carry_cnt not all-ones, carry_cnt SHALL increment by 1.
REQ-020 carry_cnt SHALL saturate at 2^CNT_W-1; no wrap-around; further carry events leave it unchanged.
REQ-021 carry_sat SHALL be a combinational decode of carry_cnt == all-ones.
REQ-022 X/Z on A or B SHALL NOT be masked; behaviour for unknown inputs is don't-care for the verifier.

Reset
REQ-023 While rst is high at a rising edge: S_r=0, Cout_r=0, out_valid=0, carry_cnt=0 (so carry_sat=0 when CNT_W>=1).
REQ-024 rst SHALL take priority over in_valid on the same edge; the simultaneous input pair is discarded.
REQ-025 Combinational S/Cout SHALL remain functional during reset.
REQ-026 Asserting rst mid-operation SHALL clear registered state on the next edge with no partial update.

Verification
REQ-027 Exhaustive combinational: A,B = 00,01,10,11, each held 10 time units -> S/Cout = 0/0, 1/0, 1/0, 0/1; PASS/FAIL is reported per vector.
REQ-028 Registered path: rst pulse, then in_valid=1, A=1, B=1 for one edge -> next cycle S_r=0, Cout_r=1, out_valid=1, carry_cnt=1.
REQ-029 Hold: in_valid=0 with A=1, B=0 for 3 edges after REQ-028 -> S_r=0, Cout_r=1 held, out_valid=0, carry_cnt=1.
REQ-030 Saturation with CNT_W=2: 5 consecutive valid 11 pairs -> carry_cnt 1,2,3,3,3; carry_sat=1 from the third.
REQ-031 Reset priority: rst=1 and in_valid=1 with A=B=1 on the same edge -> all registered outputs 0, carry_cnt=0.
REQ-032 Non-carry pairs: valid 01 then 10 -> S_r=1 each cycle, Cout_r=0, carry_cnt unchanged.
